// File: rtl/modq_pkg.sv
// Shared constants, operand bundle and wide folding helper for the mod-q reduction
// datapath (q = 2^255 - 19).
package modq_pkg;

  localparam int H0_W   = 254;
  localparam int L0_W   = 256;
  localparam int M0_W   = 258;
  localparam int RES_W  = 255;
  localparam int KARA_K = 128;

  localparam logic [RES_W-1:0] Q = {{(RES_W-8){1'b1}}, 8'hED};

  typedef struct packed {
    logic [H0_W-1:0] h0;
    logic [L0_W-1:0] l0;
    logic [M0_W-1:0] m0;
  } kara_t;

  // Folds a value below 2^512 into [0, q) using 2^255 == 19 (mod q).
  function automatic logic [RES_W-1:0] reduce_512(input logic [511:0] x);
    logic [262:0] s1;
    logic [255:0] s2;
    s1 = 263'(x[511:255]) * 263'd19 + 263'(x[254:0]);
    s2 = 256'(s1[262:255]) * 256'd19 + 256'(s1[254:0]);
    // After the second fold s2 < 2^255 + 4845 < 2q, so one subtraction suffices.
    if (s2 >= {1'b0, Q}) s2 = s2 - {1'b0, Q};
    return s2[RES_W-1:0];
  endfunction

endpackage

// File: rtl/modq_arbiter_modq.sv
// ModQ: recombines a Karatsuba triple (H0, L0, M0) with split point 2^128 and
// returns the registered residue mod q one cycle later.
module ModQ
  import modq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [H0_W-1:0]  h0,
  input  logic [L0_W-1:0]  l0,
  input  logic [M0_W-1:0]  m0,
  output logic [RES_W-1:0] res
);

  logic [256:0]     hl_sum;
  logic [511:0]     pos_w;
  logic [511:0]     neg_w;
  logic [RES_W-1:0] pos_r;
  logic [RES_W-1:0] neg_r;
  logic [RES_W-1:0] res_d;
  logic [RES_W-1:0] res_q;

  // value = H*2^256 + M*2^128 + L - (H+L)*2^128; both sides reduced, then subtracted mod q.
  always_comb begin
    hl_sum = {3'b0, h0} + {1'b0, l0};
    pos_w  = {2'b0, h0, 256'b0} + {126'b0, m0, 128'b0} + {256'b0, l0};
    neg_w  = {127'b0, hl_sum, 128'b0};
    pos_r  = reduce_512(pos_w);
    neg_r  = reduce_512(neg_w);
    res_d  = (pos_r >= neg_r) ? (pos_r - neg_r) : (pos_r + (Q - neg_r));
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (rst) res_q <= '0;
    else     res_q <= res_d;
  end

  assign res = res_q;

endmodule

// File: rtl/modq_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of mask at or after ptr,
// wrapping modulo NREQ; produces one-hot grant, its index and an any flag.
module rr_pick
  import modq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a latch.
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && mask[(int'(ptr) + k) % NREQ]) begin
        onehot[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = IDW'((int'(ptr) + k) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modq_arbiter.sv
// Round-robin arbiter sharing one ModQ reducer among NREQ requesters.
// Define MODQ_ARB_PRIO0_EN to give requester 0 fixed absolute priority.
module modq_arbiter
  import modq_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arb_en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*H0_W-1:0] req_h0,
  input  logic [NREQ*L0_W-1:0] req_l0,
  input  logic [NREQ*M0_W-1:0] req_m0,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [RES_W-1:0]     rsp_data,
  output logic                 busy
);

  logic [NREQ-1:0]  cand;
  logic [NREQ-1:0]  pick_mask;
  logic [NREQ-1:0]  pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             prio_hit;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  kara_t            win_ops;
  logic [RES_W-1:0] modq_res;

  logic [IDW-1:0]   rr_ptr_d, rr_ptr_q;
  logic [IDW-1:0]   pend_id_d, pend_id_q;
  logic             pend_vld_d, pend_vld_q;

  assign cand = req_valid & {NREQ{arb_en}};

`ifdef MODQ_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the pointer only cycles among 1..NREQ-1.
  assign prio_hit  = cand[0];
  assign pick_mask = cand & ~NREQ'(1);
`else
  assign prio_hit  = 1'b0;
  assign pick_mask = cand;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .mask   (pick_mask),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    grant    = pick_onehot;
    win_idx  = pick_idx;
    win_any  = pick_any;
    rr_ptr_d = rr_ptr_q;
    if (prio_hit) begin
      grant   = NREQ'(1);
      win_idx = '0;
      win_any = 1'b1;
    end else if (pick_any) begin
      rr_ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end

    pend_vld_d = win_any;
    pend_id_d  = win_any ? win_idx : pend_id_q;

    win_ops = '0;
    if (win_any) begin
      win_ops.h0 = req_h0[int'(win_idx) * H0_W +: H0_W];
      win_ops.l0 = req_l0[int'(win_idx) * L0_W +: L0_W];
      win_ops.m0 = req_m0[int'(win_idx) * M0_W +: M0_W];
    end
  end

  ModQ u_modq (
    .clk (clk),
    .rst (~rst),
    .h0  (win_ops.h0),
    .l0  (win_ops.l0),
    .m0  (win_ops.m0),
    .res (modq_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (pend_vld_q) rsp_valid[pend_id_q] = 1'b1;
  end

  assign req_ready = grant;
  assign rsp_id    = pend_id_q;
  assign rsp_data  = modq_res & {RES_W{pend_vld_q}};
  assign busy      = |req_valid | pend_vld_q;

endmodule

// File: tb/tb_modq_arbiter.sv
// Self-checking bench for modq_arbiter: vector table plus scoreboard of expected
// responses, with hand sequences for mid-operation reset and fairness/priority.
module tb_modq_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam logic [254:0] TB_Q = {{247{1'b1}}, 8'hED};

  logic                clk = 1'b0;
  logic                rst;
  logic                arb_en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*254-1:0] req_h0;
  logic [NREQ*256-1:0] req_l0;
  logic [NREQ*258-1:0] req_m0;
  logic [NREQ-1:0]     rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [254:0]        rsp_data;
  logic                busy;

  always #5 clk = ~clk;

  modq_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_h0    (req_h0),
    .req_l0    (req_l0),
    .req_m0    (req_m0),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]   valid;
    logic         en;
    logic [253:0] h0;
    logic [255:0] l0;
    logic [257:0] m0;
    logic [3:0]   exp_ready;
    logic         exp_busy;
    string        name;
  } vec_t;

  typedef struct {
    logic [1:0]   id;
    logic [254:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [253:0] op_h[NREQ];
  logic [255:0] op_l[NREQ];
  logic [257:0] op_m[NREQ];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Direct big-integer reference: offset by q*2^140 keeps the Karatsuba middle term non-negative.
  function automatic logic [254:0] model(input logic [253:0] h, input logic [255:0] l,
                                         input logic [257:0] m);
    logic [519:0] v;
    v = ({266'b0, h} << 256) + ({262'b0, m} << 128) + {264'b0, l} + ({265'b0, TB_Q} << 140)
        - (({266'b0, h} + {264'b0, l}) << 128);
    v = v % {265'b0, TB_Q};
    return v[254:0];
  endfunction

  function automatic logic [257:0] rand_w();
    logic [287:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v = {v[255:0], 32'($urandom())};
    return v[257:0];
  endfunction

  task automatic set_random(input int i);
    logic [257:0] r;
    r = rand_w(); op_h[i] = r[253:0];
    r = rand_w(); op_l[i] = r[255:0];
    r = rand_w(); op_m[i] = r;
  endtask

  task automatic add(input logic [3:0] v, input logic en, input logic [253:0] h,
                     input logic [255:0] l, input logic [257:0] m, input logic [3:0] er,
                     input logic eb, input string nm);
    vecs.push_back('{valid: v, en: en, h0: h, l0: l, m0: m, exp_ready: er, exp_busy: eb, name: nm});
  endtask

  // One cycle: check last cycle's response, drive new request, check grant and busy.
  task automatic step(input logic [3:0] valid, input logic en, input logic [3:0] exp_ready,
                      input logic exp_busy, input string name);
    rsp_t       e;
    logic [3:0] oh;
    @(negedge clk);
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      oh = 4'b0001 << e.id;
      check({name, " rsp_valid"}, 256'(rsp_valid), 256'(oh));
      check({name, " rsp_id"},    256'(rsp_id),    256'(e.id));
      check({name, " rsp_data"},  256'(rsp_data),  256'(e.data));
    end else begin
      check({name, " rsp_valid idle"}, 256'(rsp_valid), 256'(0));
      check({name, " rsp_data idle"},  256'(rsp_data),  256'(0));
    end
    req_valid = valid;
    arb_en    = en;
    for (int i = 0; i < NREQ; i++) begin
      req_h0[i*254 +: 254] = op_h[i];
      req_l0[i*256 +: 256] = op_l[i];
      req_m0[i*258 +: 258] = op_m[i];
    end
    #1;
    check({name, " req_ready"}, 256'(req_ready), 256'(exp_ready));
    check({name, " busy"},      256'(busy),      256'(exp_busy));
    for (int i = 0; i < NREQ; i++)
      if (exp_ready[i]) sb.push_back('{id: 2'(i), data: model(op_h[i], op_l[i], op_m[i])});
  endtask

  initial begin
    logic [255:0] q_l, q7_l;
    logic [257:0] q_m, q7_m, r;
    logic [253:0] rh;
    logic [255:0] rl;

    q_l  = {1'b0, TB_Q};
    q7_l = {1'b0, TB_Q} + 256'd7;
    q_m  = {3'b0, TB_Q};
    q7_m = {3'b0, TB_Q} + 258'd7;

`ifndef MODQ_ARB_PRIO0_EN
    add(4'b0100, 1, '0, 256'd5, 258'd5, 4'b0100, 1, "single_req2");
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 1, "idle_after_single");
    for (int k = 0; k < 8; k++)
      add(4'b1111, 1, '0, 256'd1, 258'd1, 4'b0001 << ((k + 3) % 4), 1, $sformatf("all_valid_%0d", k));
    add(4'b1111, 0, '0, '0, '0, 4'b0000, 1, "drain_en0");
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 0, "quiet");
    add(4'b0001, 1, '0, q_l, q_m, 4'b0001, 1, "residue_q");
    add(4'b0011, 1, '0, q7_l, q7_m, 4'b0010, 1, "residue_q_plus_7");
    for (int k = 0; k < 4; k++) begin
      r = rand_w(); rh = r[253:0];
      r = rand_w(); rl = r[255:0];
      r = rand_w();
      case (k)
        0:       add(4'b0001, 1, rh, rl, r, 4'b0001, 1, "rand_a");
        1:       add(4'b1010, 1, rh, rl, r, 4'b0010, 1, "rand_b");
        2:       add(4'b1010, 1, rh, rl, r, 4'b1000, 1, "rand_c");
        default: add(4'b1100, 1, rh, rl, r, 4'b0100, 1, "rand_d");
      endcase
    end
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 1, "tail_pend");
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 0, "tail_idle");
`else
    for (int k = 0; k < 4; k++)
      add(4'b1001, 1, '0, 256'd5, 258'd5, 4'b0001, 1, $sformatf("prio0_hold_%0d", k));
    add(4'b1000, 1, '0, q7_l, q7_m, 4'b1000, 1, "prio0_drop");
    add(4'b1111, 1, '0, q_l, q_m, 4'b0001, 1, "prio0_all");
    add(4'b1110, 1, '0, 256'd9, 258'd9, 4'b0010, 1, "rr_1");
    add(4'b1110, 1, '0, 256'd3, 258'd3, 4'b0100, 1, "rr_2");
    add(4'b1111, 1, '0, 256'd4, 258'd4, 4'b0001, 1, "prio0_again");
    add(4'b1110, 1, '0, 256'd6, 258'd6, 4'b1000, 1, "rr_3");
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 1, "tail_pend");
    add(4'b0000, 1, '0, '0, '0, 4'b0000, 0, "tail_idle");
`endif

    rst       = 1'b0;
    arb_en    = 1'b0;
    req_valid = '0;
    req_h0    = '0;
    req_l0    = '0;
    req_m0    = '0;
    for (int i = 0; i < NREQ; i++) begin
      op_h[i] = '0; op_l[i] = '0; op_m[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset req_ready", 256'(req_ready), 256'(0));
    check("reset rsp_valid", 256'(rsp_valid), 256'(0));
    check("reset rsp_id",    256'(rsp_id),    256'(0));
    check("reset rsp_data",  256'(rsp_data),  256'(0));
    check("reset busy",      256'(busy),      256'(0));
    rst = 1'b1;

    foreach (vecs[n]) begin
      for (int i = 0; i < NREQ; i++) begin
        if (vecs[n].exp_ready[i]) begin
          op_h[i] = vecs[n].h0; op_l[i] = vecs[n].l0; op_m[i] = vecs[n].m0;
        end else begin
          set_random(i);
        end
      end
      step(vecs[n].valid, vecs[n].en, vecs[n].exp_ready, vecs[n].exp_busy, vecs[n].name);
    end

    // Grant, then reset in the following cycle: the in-flight result must vanish at once.
    for (int i = 0; i < NREQ; i++) set_random(i);
    step(4'b0100, 1, 4'b0100, 1, "pre_reset_grant");
    @(posedge clk);
    #2;
    req_valid = '0;
    rst = 1'b0;
    #1;
    check("midreset rsp_valid", 256'(rsp_valid), 256'(0));
    check("midreset rsp_data",  256'(rsp_data),  256'(0));
    check("midreset busy",      256'(busy),      256'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;

`ifndef MODQ_ARB_PRIO0_EN
    for (int i = 0; i < NREQ; i++) begin
      op_h[i] = '0; op_l[i] = 256'd1; op_m[i] = 258'd1;
    end
    for (int k = 0; k < 8; k++)
      step(4'b1111, 1, 4'b0001 << (k % 4), 1, $sformatf("fair_%0d", k));
`else
    for (int i = 0; i < NREQ; i++) set_random(i);
    for (int k = 0; k < 3; k++)
      step(4'b1001, 1, 4'b0001, 1, $sformatf("post_reset_prio0_%0d", k));
    step(4'b1000, 1, 4'b1000, 1, "post_reset_req3");
`endif
    step(4'b0000, 1, 4'b0000, 1, "final_pend");
    step(4'b0000, 1, 4'b0000, 0, "final_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
